// File: rtl/syn_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syn_gpu_pkg
// Description : Shared pixel types, widths and Q10 RGB->YCbCr coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
package syn_gpu_pkg;

    localparam int P_RGB_RES = 4;
    localparam int P_LUM_W   = 4;
    localparam int P_CHRM_W  = 2;

    // Accumulator width: the largest magnitude (15*689 + 15*205 + 15*70 + 2048)
    // stays well inside a signed 16-bit range.
    localparam int c_acc_w = 16;

    typedef logic signed [c_acc_w-1:0] acc_t;

    typedef struct packed {
        logic [P_RGB_RES-1:0] r;
        logic [P_RGB_RES-1:0] g;
        logic [P_RGB_RES-1:0] b;
    } pxl_rgb_t;

    typedef struct packed {
        logic [P_LUM_W-1:0]  y;
        logic [P_CHRM_W-1:0] cb;
        logic [P_CHRM_W-1:0] cr;
    } pxl_ycbcr_t;

    // Q10 signed coefficients, row = output channel (Y, Cb, Cr), column = R, G, B.
    localparam acc_t c_coef [3][3] = '{
        '{ 16'sd205,  16'sd689,  16'sd70 },
        '{-16'sd22,  -16'sd74,   16'sd96 },
        '{ 16'sd96,  -16'sd65,  -16'sd9  }
    };

    // Q10 offsets per output channel (chroma is centred at 1.5).
    localparam acc_t c_off [3] = '{16'sd0, 16'sd1536, 16'sd1536};

endpackage
`default_nettype wire

// File: rtl/syn_clamp.sv
`default_nettype none
// ============================================================================
// Module      : syn_clamp
// Description : Saturates a signed value to the unsigned range 0 .. 2**OUT_W-1.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_clamp #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
) (
    input  logic signed [IN_W-1:0] i_val,
    output logic [OUT_W-1:0]       o_val
);

    localparam logic signed [IN_W-1:0] c_max = IN_W'((2 ** OUT_W) - 1);

    // Negative inputs floor at zero, oversized inputs saturate at all-ones.
    always_comb begin
        o_val = i_val[OUT_W-1:0];
        if (i_val[IN_W-1]) begin
            o_val = '0;
        end else if (i_val > c_max) begin
            o_val = '1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/syn_rgb2ycbcr_conv.sv
`default_nettype none
// ============================================================================
// Module      : syn_rgb2ycbcr_conv
// Description : Three-stage valid/ready RGB444 -> YCbCr(4/2/2-bit) converter
//               with sideband pass-through and an output pixel counter.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_rgb2ycbcr_conv
    import syn_gpu_pkg::*;
#(
    parameter int P_FRAC_W = 10
) (
    input  logic        clk_ir,
    input  logic        rst_ih,
    input  pxl_rgb_t    pxl_rgb_i,
    input  logic        pxl_sof_i,
    input  logic        pxl_eol_i,
    input  logic        pxl_valid_i,
    output logic        pxl_ready_o,
    output pxl_ycbcr_t  pxl_ycbcr_o,
    output logic        pxl_sof_o,
    output logic        pxl_eol_o,
    output logic        pxl_valid_o,
    input  logic        pxl_ready_i,
    output logic [31:0] pxl_cnt_o
);

    localparam acc_t c_round = acc_t'(2 ** (P_FRAC_W - 1));

    logic                w_en;
    acc_t                w_in      [3];
    acc_t                r_s1_prod [3][3];
    acc_t                r_s2_acc  [3];
    logic                r_s1_vld;
    logic                r_s1_sof;
    logic                r_s1_eol;
    logic                r_s2_vld;
    logic                r_s2_sof;
    logic                r_s2_eol;
    logic [P_LUM_W-1:0]  w_y;
    logic [P_CHRM_W-1:0] w_cb;
    logic [P_CHRM_W-1:0] w_cr;

    // The whole pipeline moves together whenever the output slot is free or drained.
    assign w_en        = ~pxl_valid_o | pxl_ready_i;
    assign pxl_ready_o = w_en;

    assign w_in[0] = acc_t'(pxl_rgb_i.r);
    assign w_in[1] = acc_t'(pxl_rgb_i.g);
    assign w_in[2] = acc_t'(pxl_rgb_i.b);

    // Valid bits and sideband travel alongside their pixel; bubbles enter as valid=0.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            r_s1_vld    <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_eol    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_sof    <= 1'b0;
            r_s2_eol    <= 1'b0;
            pxl_valid_o <= 1'b0;
            pxl_sof_o   <= 1'b0;
            pxl_eol_o   <= 1'b0;
        end else if (w_en) begin
            r_s1_vld    <= pxl_valid_i;
            r_s1_sof    <= pxl_sof_i;
            r_s1_eol    <= pxl_eol_i;
            r_s2_vld    <= r_s1_vld;
            r_s2_sof    <= r_s1_sof;
            r_s2_eol    <= r_s1_eol;
            pxl_valid_o <= r_s2_vld;
            pxl_sof_o   <= r_s2_sof;
            pxl_eol_o   <= r_s2_eol;
        end
    end

    // Stage 1: register all nine coefficient products.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    r_s1_prod[ch][k] <= '0;
                end
            end
        end else if (w_en) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    r_s1_prod[ch][k] <= c_coef[ch][k] * w_in[k];
                end
            end
        end
    end

    // Stage 2: sum products, add channel offset and half-LSB, then floor-shift.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            for (int ch = 0; ch < 3; ch++) begin
                r_s2_acc[ch] <= '0;
            end
        end else if (w_en) begin
            for (int ch = 0; ch < 3; ch++) begin
                r_s2_acc[ch] <= (r_s1_prod[ch][0] + r_s1_prod[ch][1] + r_s1_prod[ch][2]
                                 + c_off[ch] + c_round) >>> P_FRAC_W;
            end
        end
    end

    syn_clamp #(.IN_W(c_acc_w), .OUT_W(P_LUM_W))  u_clamp_y  (.i_val(r_s2_acc[0]), .o_val(w_y));
    syn_clamp #(.IN_W(c_acc_w), .OUT_W(P_CHRM_W)) u_clamp_cb (.i_val(r_s2_acc[1]), .o_val(w_cb));
    syn_clamp #(.IN_W(c_acc_w), .OUT_W(P_CHRM_W)) u_clamp_cr (.i_val(r_s2_acc[2]), .o_val(w_cr));

    // Stage 3: register the clamped, packed output pixel.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            pxl_ycbcr_o <= '0;
        end else if (w_en) begin
            pxl_ycbcr_o <= '{y: w_y, cb: w_cb, cr: w_cr};
        end
    end

    // Count output transfers; a start-of-frame pixel restarts the count at one.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            pxl_cnt_o <= '0;
        end else if (pxl_valid_o && pxl_ready_i) begin
            pxl_cnt_o <= pxl_sof_o ? 32'd1 : pxl_cnt_o + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/syn_rgb2ycbcr_conv.md
SYN_RGB2YCBCR_CONV -- requirements
Module: syn_rgb2ycbcr_conv

Interface
REQ-001 Parameter: P_FRAC_W, 10, fractional bits of fixed-point coefficients and offsets.
REQ-002 Ports: clk_ir  in  1  single clock; all state on rising edge.
REQ-003 Ports: rst_ih  in  1  reset, asynchronous assert, active-high.
REQ-004 Ports: pxl_rgb_i  in  pxl_rgb_t (3 x P_RGB_RES)  input pixel, red/green/blue 0..15.
REQ-005 Ports: pxl_sof_i / pxl_eol_i  in  1 each  start-of-frame / end-of-line sideband.
REQ-006 Ports: pxl_valid_i  in  1 and pxl_ready_o  out  1  input handshake.
REQ-007 Ports: pxl_ycbcr_o  out  pxl_ycbcr_t (P_LUM_W + 2 x P_CHRM_W)  output pixel, y 0..15, cb/cr 0..3.
REQ-008 Ports: pxl_sof_o / pxl_eol_o  out  1 each  sideband aligned with pxl_ycbcr_o.
REQ-009 Ports: pxl_valid_o  out  1 and pxl_ready_i  in  1  output handshake.
REQ-010 Ports: pxl_cnt_o  out  32  pixels accepted at output since reset or last SOF.

Function
REQ-011 Transfer occurs on a cycle where valid and ready are both high; valid, data and sideband stay stable while valid is high and ready is low.
REQ-012 Three-stage pipeline: S1 registered products, S2 sum + offset + rounding, S3 clamp + pack; minimum latency 3 cycles from input transfer to pxl_valid_o.
REQ-013 Pipeline enable en = ~pxl_valid_o | pxl_ready_i; all stages and their valid bits advance only when en is high; pxl_ready_o = en.
REQ-014 Stage valid bits shift with en; bubbles propagate as valid=0; no pixel is lost or duplicated under any ready pattern.
REQ-015 Coefficients, Q10 signed: Y = 205R + 689G + 70B; Cb = 1536 - 22R - 74G + 96B; Cr = 1536 + 96R - 65G - 9B.
REQ-016 Rounding: add 512, arithmetic shift right by P_FRAC_W; accumulators are at least 16-bit signed with no overflow for any input.
REQ-017 Clamp: Y to 0..15, Cb/Cr to 0..3; negative results give 0.
REQ-018 Sideband sof/eol is carried through the same stages as its pixel.
REQ-019 pxl_cnt_o increments on each output transfer and wraps from 0xFFFFFFFF to 0; an output transfer with sof set loads 1.
REQ-020 Simultaneous input and output transfers in one cycle are legal; throughput is one pixel per cycle while pxl_ready_i is held high.

Reset
REQ-021 While rst_ih is high: all stage valid bits are 0, pxl_valid_o=0, pxl_ycbcr_o=0, pxl_sof_o=0, pxl_eol_o=0, pxl_cnt_o=0, and pxl_ready_o=1 (derived from pxl_valid_o=0).
REQ-022 Reset asserted mid-frame discards all in-flight pixels with no partial output after release.

Structure
REQ-023 pxl_rgb_t, pxl_ycbcr_t, P_RGB_RES, P_LUM_W and P_CHRM_W are taken from syn_gpu_pkg; Q10 coefficient localparams are added to syn_gpu_pkg.
REQ-024 One sub-module, syn_clamp, implements a generic saturate-to-unsigned-N-bit function and is instantiated three times.

Verification
REQ-025 Black RGB(0,0,0) -> YCbCr(0,2,2); white (15,15,15) -> Y=14, Cb=2, Cr=2.
REQ-026 Red (15,0,0) -> (3,1,3); green (0,15,0) -> (10,0,1); blue (0,0,15) -> (1,3,1); each 3 cycles after acceptance with pxl_ready_i=1.
REQ-027 All 4096 RGB inputs streamed -> exact match to the REQ-015..017 integer model; within ±1 LSB of the real-valued conversion model.
REQ-028 Random pxl_valid_i and pxl_ready_i (50% each) over 10000 pixels -> in-order output, no loss or duplicate, stable output during stall.
REQ-029 SOF on pixel 0 and EOL every 640 pixels -> flags aligned on output; pxl_cnt_o reloads to 1 at each SOF.
REQ-030 rst_ih pulsed with 3 pixels in flight -> pxl_valid_o low next cycle, pxl_cnt_o=0, first post-reset output equals first post-reset input.
